// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants bounded bursts of up to MAX_BURST beats and stalls while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned OWN_W      = $clog2(NREQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]            gnt_o,
  input  logic                       full_i,
  input  logic                       overflow_i,
  output logic                       wt_en_o,
  output logic [DATA_WIDTH-1:0]      wdata_o,
  output logic [OWN_W-1:0]           owner_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q;

  logic              beat;
  logic              found;
  logic [OWN_W-1:0]  pick;
  logic [OWN_W-1:0]  cand;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OWN_W'((32'(last_q) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign beat = (state_q == StBurst) && req_i[owner_q] && !full_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(MAX_BURST - 1)) begin
            state_d = StIdle;
            last_d  = owner_q;
          end
        end else if (!req_i[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OWN_W'(NREQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | overflow_i;
    end
  end

  always_comb begin
    wt_en_o = beat;
    gnt_o   = '0;
    wdata_o = '0;
    if (beat) begin
      gnt_o[owner_q] = 1'b1;
      wdata_o        = req_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q == StBurst);
  assign err_o   = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural arbiter model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;
  localparam int OW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic                 full, overflow;
  logic [NREQ-1:0]      gnt;
  logic                 wt_en;
  logic [DW-1:0]        wdata;
  logic [OW-1:0]        owner;
  logic                 busy, err;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB), .OWN_W(OW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_data_i(req_data), .gnt_o(gnt),
    .full_i(full), .overflow_i(overflow), .wt_en_o(wt_en), .wdata_o(wdata),
    .owner_o(owner), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester side: words left to send and current word.
  int          rem[NREQ];
  logic [DW-1:0] dat[NREQ];
  bit          rnd_data = 1'b0;

  // Behavioural arbiter model.
  bit m_busy, m_err;
  int m_owner, m_last, m_cnt;

  // Observations from the most recent cycle.
  logic          obs_we, obs_busy, obs_err;
  logic [NREQ-1:0] obs_gnt;
  logic [DW-1:0] obs_wd;
  logic [OW-1:0] obs_owner;
  logic [DW-1:0] wlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  task automatic cycle();
    bit beat;
    logic [NREQ-1:0] eg;
    logic [DW-1:0] ew;
    drive();
    @(negedge clk);
    beat = m_busy && req[m_owner] && !full;
    eg = beat ? (NREQ'(1) << m_owner) : '0;
    ew = beat ? dat[m_owner] : '0;
    chk("wt_en", 32'(wt_en), 32'(beat));
    chk("gnt", 32'(gnt), 32'(eg));
    chk("wdata", 32'(wdata), 32'(ew));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err", 32'(err), 32'(m_err));
    obs_we = wt_en; obs_gnt = gnt; obs_wd = wdata; obs_owner = owner;
    obs_busy = busy; obs_err = err;
    if (wt_en) wlog.push_back(wdata);
    @(posedge clk);
    if (rst_n) begin
      if (overflow) m_err = 1;
      if (!m_busy) begin
        if (|req) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_last + k) % NREQ]) begin
              m_owner = (m_last + k) % NREQ;
              break;
            end
          end
          m_busy = 1; m_cnt = 0;
        end
      end else if (beat) begin
        m_cnt++;
        rem[m_owner]--;
        dat[m_owner] = rnd_data ? DW'($urandom) : dat[m_owner] + 1'b1;
        if (m_cnt == MB) begin m_busy = 0; m_last = m_owner; end
      end else if (!req[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; full = 1'b0; overflow = 1'b0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] exp_wd[10];
    logic [OW-1:0] own_seq[$];
    int nw;
    bit prev_we;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; dat[i] = '0; end
    rst_n = 1'b0; full = 1'b0; overflow = 1'b0;
    model_reset();
    drive();
    #3;
    chk("rst_wt_en", 32'(wt_en), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Single requester: 0x10..0x13, bubble, 0x14..0x17.
    do_reset();
    rem[2] = 100; dat[2] = 8'h10;
    wlog.delete();
    for (int c = 0; c < 11; c++) begin
      cycle();
      chk("single_we", 32'(obs_we), (c == 0 || c == 5 || c == 10) ? 0 : 1);
      if (obs_we) chk("single_gnt", 32'(obs_gnt), 32'h4);
      if (c > 0) chk("single_owner", 32'(obs_owner), 2);
    end
    for (int i = 0; i < 8; i++) exp_wd[i] = DW'(8'h10 + i);
    chk("single_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("single_data", 32'(wlog[i]), 32'(exp_wd[i]));

    // Round-robin with all four requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 100; dat[i] = DW'(i * 32); end
    cycle();
    nw = 0; prev_we = 0;
    for (int c = 0; c < 22; c++) begin
      cycle();
      if (c < 20 && obs_we) nw++;
      if (obs_we && !prev_we) own_seq.push_back(obs_owner);
      prev_we = obs_we;
    end
    chk("rr_writes_20cyc", nw, 16);
    chk("rr_bursts", own_seq.size(), 5);
    for (int i = 0; i < 5 && i < own_seq.size(); i++) chk("rr_owner_seq", 32'(own_seq[i]), i % 4);

    // Full stall at count 2 for requester 1.
    do_reset();
    rem[1] = 8; dat[1] = 8'h40;
    cycle(); cycle(); cycle();
    chk("stall_pre_we", 32'(obs_we), 1);
    full = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_we", 32'(obs_we), 0);
      chk("stall_gnt", 32'(obs_gnt), 0);
      chk("stall_busy", 32'(obs_busy), 1);
      chk("stall_owner", 32'(obs_owner), 1);
    end
    full = 1'b0;
    cycle(); chk("stall_beat3", 32'(obs_wd), 32'h42); chk("stall_we3", 32'(obs_we), 1);
    cycle(); chk("stall_beat4", 32'(obs_wd), 32'h43); chk("stall_we4", 32'(obs_we), 1);
    cycle(); chk("stall_idle", 32'(obs_busy), 0); chk("stall_idle_we", 32'(obs_we), 0);

    // Early release by requester 3 after two beats; next owner wraps to 0.
    do_reset();
    rem[3] = 2; dat[3] = 8'h30;
    cycle();
    rem[0] = 5; dat[0] = 8'h50;
    cycle(); cycle();
    chk("early_beat2_owner", 32'(obs_owner), 3);
    cycle(); chk("early_rel_busy", 32'(obs_busy), 1); chk("early_rel_we", 32'(obs_we), 0);
    cycle(); chk("early_idle", 32'(obs_busy), 0);
    cycle(); chk("early_next_owner", 32'(obs_owner), 0); chk("early_next_we", 32'(obs_we), 1);

    // Asynchronous reset during a beat.
    do_reset();
    rem[0] = 10; rem[3] = 10; dat[0] = 8'h60; dat[3] = 8'h70;
    for (int n = 0; n < 20 && !(m_busy && m_cnt == 1); n++) cycle();
    chk("arst_mid_prev_we", 32'(obs_we), 1);
    drive();
    #2;
    chk("arst_pre_we", 32'(wt_en), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(wt_en), 0);
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    chk("arst_first_owner", 32'(owner), 0);
    chk("arst_first_busy", 32'(busy), 1);

    // Sticky overflow error.
    do_reset();
    overflow = 1'b1;
    cycle();
    overflow = 1'b0;
    chk("ovf_before", 32'(obs_err), 0);
    cycle(); chk("ovf_set", 32'(obs_err), 1);
    repeat (3) cycle();
    chk("ovf_held", 32'(obs_err), 1);
    rst_n = 1'b0;
    #1;
    chk("ovf_cleared", 32'(err), 0);
    do_reset();

    // Randomized traffic against the model.
    rnd_data = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(7, 0) == 0) begin
          rem[i] = $urandom_range(7, 1);
          dat[i] = DW'($urandom);
        end
      end
      full = ($urandom_range(3, 0) == 0);
      overflow = ($urandom_range(63, 0) == 0);
      if ($urandom_range(399, 0) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
